// File: rtl/sum_accumulator_pkg.sv
// Shared types and width helpers for the sum accumulator.
package sum_accumulator_pkg;

  typedef enum logic {
    S_EMPTY,
    S_ACCUM
  } accum_state_e;

  function automatic int acc_width(input int width_in, input int acc_len);
    return width_in + $clog2(acc_len);
  endfunction

endpackage

// File: rtl/sum_accumulator_outbuf.sv
// Single-entry output register: loads a window total, holds it until the consumer takes it.
module sum_accumulator_outbuf #(
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout
);

  // A load in the same cycle as a drain keeps the register full with the new total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      dout      <= data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates ACC_LEN consecutive adder sums and hands each window total to a valid/ready consumer.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int WIDTH_IN  = 19,
  parameter int ACC_LEN   = 8,
  parameter int IS_SIGNED = 0,
  parameter int TRUNCATE  = 0,
  localparam int WIDTH_ACC = acc_width(WIDTH_IN, ACC_LEN),
  localparam int WIDTH_OUT = (TRUNCATE != 0) ? WIDTH_IN : WIDTH_ACC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  din,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] dout
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  function automatic logic signed [WIDTH_ACC-1:0] extend(input logic [WIDTH_IN-1:0] v);
    if (IS_SIGNED != 0) return WIDTH_ACC'(signed'(v));
    return signed'(WIDTH_ACC'(v));
  endfunction

  // Low bits only: wrap, never saturate.
  function automatic logic [WIDTH_OUT-1:0] wrap_out(input logic signed [WIDTH_ACC-1:0] v);
    return v[WIDTH_OUT-1:0];
  endfunction

  accum_state_e                state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic signed [WIDTH_ACC-1:0] acc, acc_nxt;
  logic signed [WIDTH_ACC-1:0] sum;
  logic                        last;
  logic                        accept;
  logic                        load;

  assign last     = (cnt == LAST);
  // Only the final beat of a window can stall, and only while the previous total is unread.
  assign in_ready = !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready && !clear;
  assign sum      = ((state == S_ACCUM) ? acc : '0) + extend(din);
  assign load     = accept && last;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    if (clear) begin
      state_nxt = S_EMPTY;
      cnt_nxt   = '0;
    end else if (accept) begin
      acc_nxt = sum;
      if (last) begin
        state_nxt = S_EMPTY;
        cnt_nxt   = '0;
      end else begin
        state_nxt = S_ACCUM;
        cnt_nxt   = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
    end
  end

  sum_accumulator_outbuf #(
    .WIDTH(WIDTH_OUT)
  ) u_outbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .data     (wrap_out(sum)),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .dout     (dout)
  );

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: four configurations driven from shared inputs.
module tb_sum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [18:0] din;
  logic        out_ready;

  logic        u_ready, u_valid;
  logic [20:0] u_dout;
  logic        s_ready, s_valid;
  logic [20:0] s_dout;
  logic        e_ready, e_valid;
  logic [18:0] e_dout;
  logic        w_ready, w_valid;
  logic [18:0] w_dout;

  int checks = 0;
  int errors = 0;

  // ACC_LEN=4 unsigned, full width
  sum_accumulator #(.WIDTH_IN(19), .ACC_LEN(4), .IS_SIGNED(0), .TRUNCATE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(u_ready),
    .din(din), .out_valid(u_valid), .out_ready(out_ready), .dout(u_dout));
  // ACC_LEN=4 signed, full width
  sum_accumulator #(.WIDTH_IN(19), .ACC_LEN(4), .IS_SIGNED(1), .TRUNCATE(0)) s_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_ready),
    .din(din), .out_valid(s_valid), .out_ready(out_ready), .dout(s_dout));
  // ACC_LEN=1 truncated: echo
  sum_accumulator #(.WIDTH_IN(19), .ACC_LEN(1), .IS_SIGNED(0), .TRUNCATE(1)) e_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(e_ready),
    .din(din), .out_valid(e_valid), .out_ready(out_ready), .dout(e_dout));
  // ACC_LEN=4 truncated: wrap
  sum_accumulator #(.WIDTH_IN(19), .ACC_LEN(4), .IS_SIGNED(0), .TRUNCATE(1)) w_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(w_ready),
    .din(din), .out_valid(w_valid), .out_ready(out_ready), .dout(w_dout));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic beat(input logic [18:0] v);
    in_valid = 1'b1;
    din = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; din = 19'd5; out_ready = 1'b0;
    #3;
    checks++; if (u_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", u_valid); end
    checks++; if (u_dout !== 21'd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", u_dout); end
    checks++; if (u_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", u_ready); end
    checks++; if (e_ready !== 1'b1) begin errors++; $display("FAIL reset_echo_ready: got %0b expected 1", e_ready); end
    idle();
    checks++; if (u_valid !== 1'b0 || e_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %0b/%0b expected 0/0", u_valid, e_valid); end
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      beat(19'(i));
      if (i < 4) begin
        checks++; if (u_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid beat %0d: got %0b expected 0", i, u_valid); end
      end
    end
    checks++; if (u_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", u_valid); end
    checks++; if (u_dout !== 21'd10) begin errors++; $display("FAIL basic_dout: got %0d expected 10", u_dout); end
    idle();
    checks++; if (u_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %0b expected 0", u_valid); end
  endtask

  task automatic test_signed_and_max();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(19'h7FFFF);
      checks++; if (e_dout !== 19'h7FFFF || e_valid !== 1'b1) begin errors++; $display("FAIL echo_max: got %0h/%0b expected 7ffff/1", e_dout, e_valid); end
    end
    checks++; if (s_dout !== 21'h1FFFFC || s_valid !== 1'b1) begin errors++; $display("FAIL signed_minus4: got %0h/%0b expected 1ffffc/1", s_dout, s_valid); end
    checks++; if (u_dout !== 21'd2097148) begin errors++; $display("FAIL unsigned_max: got %0d expected 2097148", u_dout); end
    checks++; if (w_dout !== 19'h7FFFC) begin errors++; $display("FAIL trunc_max: got %0h expected 7fffc", w_dout); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) beat(19'(i));
    out_ready = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      in_valid = 1'b1; din = 19'(i);
      #1;
      checks++; if (u_ready !== 1'b1) begin errors++; $display("FAIL bp_ready beat %0d: got %0b expected 1", i, u_ready); end
      idle();
    end
    in_valid = 1'b1; din = 19'd8;
    #1;
    checks++; if (u_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: got %0b expected 0", u_ready); end
    for (int k = 0; k < 2; k++) begin
      idle();
      checks++; if (u_valid !== 1'b1 || u_dout !== 21'd10 || u_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: got valid=%0b dout=%0d ready=%0b expected 1/10/0", u_valid, u_dout, u_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (u_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %0b expected 1", u_ready); end
    idle();
    in_valid = 1'b0;
    checks++; if (u_valid !== 1'b1 || u_dout !== 21'd26) begin errors++; $display("FAIL bp_second: got %0b/%0d expected 1/26", u_valid, u_dout); end
    idle();
    checks++; if (u_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b expected 0", u_valid); end
  endtask

  task automatic test_clear();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) beat(19'(i));
    beat(19'd9);
    beat(19'd9);
    clear = 1'b1; in_valid = 1'b1; din = 19'd100;
    idle();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (u_valid !== 1'b1 || u_dout !== 21'd10) begin errors++; $display("FAIL clear_keeps_out: got %0b/%0d expected 1/10", u_valid, u_dout); end
    out_ready = 1'b1;
    beat(19'd1);
    checks++; if (u_valid !== 1'b0) begin errors++; $display("FAIL clear_restart: got %0b expected 0", u_valid); end
    beat(19'd1);
    beat(19'd1);
    beat(19'd1);
    checks++; if (u_valid !== 1'b1 || u_dout !== 21'd4) begin errors++; $display("FAIL clear_window: got %0b/%0d expected 1/4", u_valid, u_dout); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) beat(19'(i));
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (u_valid !== 1'b0 || u_dout !== 21'd0 || u_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got valid=%0b dout=%0d ready=%0b expected 0/0/1", u_valid, u_dout, u_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(19'd7);
    checks++; if (u_valid !== 1'b1 || u_dout !== 21'd28) begin errors++; $display("FAIL async_after: got %0b/%0d expected 1/28", u_valid, u_dout); end
  endtask

  task automatic test_truncate();
    logic [18:0] v;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(19'h40000);
      checks++; if (e_dout !== 19'h40000) begin errors++; $display("FAIL echo_pow: got %0h expected 40000", e_dout); end
    end
    checks++; if (w_valid !== 1'b1 || w_dout !== 19'd0) begin errors++; $display("FAIL trunc_wrap: got %0b/%0h expected 1/0", w_valid, w_dout); end
    checks++; if (u_dout !== 21'h100000) begin errors++; $display("FAIL full_pow: got %0h expected 100000", u_dout); end
    for (int i = 0; i < 6; i++) begin
      v = 19'($urandom);
      beat(v);
      checks++; if (e_valid !== 1'b1 || e_dout !== v) begin errors++; $display("FAIL echo_rand: got %0b/%0h expected 1/%0h", e_valid, e_dout, v); end
    end
  endtask

  task automatic test_random();
    int          beats;
    longint      usum, ssum;
    logic [20:0] uval, sval;
    logic        pend, exp_ready, acc, done;
    logic signed [18:0] sd;
    do_reset();
    beats = 0; usum = 0; ssum = 0; pend = 1'b0; uval = '0; sval = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      din       = 19'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 15) == 0);
      #1;
      exp_ready = !(beats == 3 && pend && !out_ready);
      checks++; if (u_ready !== exp_ready || s_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready cyc %0d: got %0b/%0b expected %0b", cyc, u_ready, s_ready, exp_ready);
      end
      checks++; if (u_valid !== pend || s_valid !== pend) begin
        errors++; $display("FAIL rand_valid cyc %0d: got %0b/%0b expected %0b", cyc, u_valid, s_valid, pend);
      end
      if (pend) begin
        checks++; if (u_dout !== uval || s_dout !== sval) begin
          errors++; $display("FAIL rand_dout cyc %0d: got %0h/%0h expected %0h/%0h", cyc, u_dout, s_dout, uval, sval);
        end
      end
      acc  = in_valid && exp_ready && !clear;
      done = 1'b0;
      if (clear) begin
        beats = 0; usum = 0; ssum = 0;
      end else if (acc) begin
        sd = signed'(din);
        usum += longint'(din);
        ssum += longint'(sd);
        beats++;
        if (beats == 4) begin
          uval = 21'(usum); sval = 21'(ssum);
          pend = 1'b1; done = 1'b1;
          beats = 0; usum = 0; ssum = 0;
        end
      end
      if (!done && out_ready) pend = 1'b0;
      idle();
    end
    clear = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_signed_and_max();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_truncate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
